perf_counter_bank: RTL and testbench

Synthesizable, parametrised event-counter bank that moves processor performance accounting into hardware. Counted events include retired instructions, I-cache and D-cache requests, and I-cache and D-cache hits. The block sits beside the processor core. It:
- counts up to NUM_CH single-bit event strobes plus a cycle counter,
- freezes all counts on the halt strobe,
- exposes every count through a registered read port, for a debug/host interface or a bench.

---
 rtl/perf_counter_bank.sv | 121 ++++++++++++
 tb/tb_perf_counter_bank.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/perf_counter_bank.sv
// Event-counter bank: NUM_CH event channels plus a cycle counter, with halt freeze,
// sticky overflow flags and a one-cycle registered read port.
module perf_counter_bank_lane #(
  parameter int CNT_W = 32,
  parameter int SAT   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             ovf_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (clr_i) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (inc_i) begin
      if (&cnt_q) begin
        ovf_d = 1'b1;
        cnt_d = (SAT != 0) ? cnt_q : '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign cnt_o = cnt_q;
  assign ovf_o = ovf_q;
endmodule

module perf_counter_bank #(
  parameter int NUM_CH = 6,
  parameter int CNT_W  = 32,
  parameter int SAT    = 0,
  parameter int SEL_W  = $clog2(NUM_CH+1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              en,
  input  logic [NUM_CH-1:0] event_in,
  input  logic              halt,
  input  logic              rd_req,
  input  logic [SEL_W-1:0]  rd_sel,
  output logic              rd_valid,
  output logic [CNT_W-1:0]  rd_data,
  output logic [NUM_CH:0]   ovf,
  output logic              frozen
);
  typedef enum logic {RUN, FROZEN} state_e;
  state_e state_q, state_d;

  logic                         cnt_en;
  logic [NUM_CH:0]              inc;
  logic [NUM_CH:0][CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]             rd_mux;
  logic                         rd_valid_q;
  logic [CNT_W-1:0]             rd_data_q, rd_data_d;

  // Top lane is the cycle counter; it counts whenever the bank is enabled.
  assign cnt_en = (state_q == RUN) && en && !clr;
  assign inc    = {cnt_en, event_in & {NUM_CH{cnt_en}}};

  for (genvar i = 0; i <= NUM_CH; i++) begin : g_lane
    perf_counter_bank_lane #(.CNT_W(CNT_W), .SAT(SAT)) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .clr_i (clr),
      .inc_i (inc[i]),
      .cnt_o (cnt[i]),
      .ovf_o (ovf[i])
    );
  end

  always_comb begin
    state_d = state_q;
    if (clr)                          state_d = RUN;
    else if (state_q == RUN && halt)  state_d = FROZEN;
  end

  // Out-of-range selects fall through to zero.
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i <= NUM_CH; i++)
      if (rd_sel == SEL_W'(i)) rd_mux = cnt[i];
  end

  assign rd_data_d = rd_req ? rd_mux : rd_data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      rd_valid_q <= rd_req;
      rd_data_q  <= rd_data_d;
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign frozen   = (state_q == FROZEN);
endmodule

// File: tb/tb_perf_counter_bank.sv
// Random + directed bench for perf_counter_bank; a wrap (SAT=0) and a saturating
// (SAT=1) instance share stimulus and are compared against a per-instance model.
module tb_perf_counter_bank;
  localparam int NC = 4;
  localparam int CW = 8;
  localparam int MAXV = (1 << CW) - 1;

  logic clk, rst_n, clr, en, halt, rd_req;
  logic [NC-1:0] event_in;
  logic [2:0]    rd_sel;
  logic [1:0]           rv;
  logic [1:0][CW-1:0]   rd;
  logic [1:0][NC:0]     ovf;
  logic [1:0]           frz;

  perf_counter_bank #(.NUM_CH(NC), .CNT_W(CW), .SAT(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .en(en), .event_in(event_in), .halt(halt),
    .rd_req(rd_req), .rd_sel(rd_sel), .rd_valid(rv[0]), .rd_data(rd[0]),
    .ovf(ovf[0]), .frozen(frz[0]));
  perf_counter_bank #(.NUM_CH(NC), .CNT_W(CW), .SAT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .en(en), .event_in(event_in), .halt(halt),
    .rd_req(rd_req), .rd_sel(rd_sel), .rd_valid(rv[1]), .rd_data(rd[1]),
    .ovf(ovf[1]), .frozen(frz[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain integer counts per instance, index NC = cycle counter.
  int  mcnt [2][NC+1];
  bit  movf [2][NC+1];
  bit  mfrz;
  bit  mrv;
  int  mrd  [2];
  int  n_chk, n_pass;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic void mreset();
    for (int s = 0; s < 2; s++) begin
      for (int c = 0; c <= NC; c++) begin mcnt[s][c] = 0; movf[s][c] = 0; end
      mrd[s] = 0;
    end
    mfrz = 0; mrv = 0;
  endfunction

  function automatic void minc(int s, int c);
    if (mcnt[s][c] == MAXV) begin
      movf[s][c] = 1;
      mcnt[s][c] = (s == 1) ? MAXV : 0;
    end else mcnt[s][c]++;
  endfunction

  function automatic void medge();
    bit frz_next;
    frz_next = mfrz;
    mrv = rd_req;
    for (int s = 0; s < 2; s++)
      if (rd_req) mrd[s] = (int'(rd_sel) <= NC) ? mcnt[s][rd_sel] : 0;
    if (clr) begin
      for (int s = 0; s < 2; s++)
        for (int c = 0; c <= NC; c++) begin mcnt[s][c] = 0; movf[s][c] = 0; end
      frz_next = 0;
    end else if (!mfrz) begin
      if (en)
        for (int s = 0; s < 2; s++) begin
          for (int c = 0; c < NC; c++) if (event_in[c]) minc(s, c);
          minc(s, NC);
        end
      if (halt) frz_next = 1;
    end
    mfrz = frz_next;
  endfunction

  task automatic check_all();
    for (int s = 0; s < 2; s++) begin
      bit [NC:0] eo;
      for (int c = 0; c <= NC; c++) eo[c] = movf[s][c];
      chk($sformatf("rd_valid[sat%0d]", s), rv[s], mrv);
      chk($sformatf("rd_data[sat%0d]", s), rd[s], mrd[s]);
      chk($sformatf("ovf[sat%0d]", s), ovf[s], eo);
      chk($sformatf("frozen[sat%0d]", s), frz[s], mfrz);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    medge();
    #1;
    check_all();
  endtask

  task automatic idle();
    en = 0; event_in = '0; halt = 0; clr = 0; rd_req = 0; rd_sel = '0;
  endtask

  task automatic rd_expect(input string tag, input int sel, input int e0, input int e1);
    idle(); rd_req = 1; rd_sel = 3'(sel);
    cyc();
    rd_req = 0;
    chk({tag, "_sat0"}, rd[0], e0);
    chk({tag, "_sat1"}, rd[1], e1);
  endtask

  task automatic run(input int n, input logic [NC-1:0] ev);
    idle(); en = 1; event_in = ev;
    for (int i = 0; i < n; i++) cyc();
    idle();
  endtask

  task automatic do_clr();
    idle(); clr = 1; cyc(); clr = 0;
  endtask

  initial begin
    n_chk = 0; n_pass = 0;
    idle(); rst_n = 0;
    mreset();
    #12;
    check_all();
    @(negedge clk); rst_n = 1;
    cyc();

    // Basic count
    run(10, 4'b0101);
    rd_expect("basic_ch0", 0, 10, 10);
    rd_expect("basic_ch1", 1, 0, 0);
    rd_expect("basic_ch2", 2, 10, 10);
    rd_expect("basic_ch3", 3, 0, 0);
    rd_expect("basic_cyc", 4, 10, 10);

    // Wrap vs saturate at 256 events, then one more
    do_clr();
    run(256, 4'b0010);
    rd_expect("wrap_ch1", 1, 0, MAXV);
    chk("wrap_ovf1_sat0", ovf[0][1], 1);
    chk("wrap_ovf1_sat1", ovf[1][1], 1);
    run(1, 4'b0010);
    rd_expect("wrap_plus1", 1, 1, MAXV);
    chk("wrap_ovf1_sticky", ovf[0][1], 1);

    // Saturate at 300 cycles
    do_clr();
    run(300, 4'b0010);
    rd_expect("sat_ch1", 1, 300 % 256, MAXV);
    rd_expect("sat_cyc", 4, 300 % 256, MAXV);
    chk("sat_ovf_cyc", ovf[1][NC], 1);

    // Halt freeze
    do_clr();
    run(4, 4'b1000);
    idle(); en = 1; event_in = 4'b1000; halt = 1; cyc();
    chk("halt_frozen", frz[0], 1);
    run(20, 4'b1000);
    rd_expect("halt_ch3", 3, 5, 5);
    do_clr();
    chk("halt_clr_frozen", frz[0], 0);
    rd_expect("halt_clr_ch3", 3, 0, 0);

    // clr + halt + events + read in one cycle
    run(7, 4'b1000);
    idle(); clr = 1; halt = 1; en = 1; event_in = 4'hF; rd_req = 1; rd_sel = 3'd3;
    cyc();
    chk("prec_preclear_rd", rd[0], 7);
    chk("prec_state_run", frz[0], 0);
    rd_expect("prec_ch3", 3, 0, 0);
    rd_expect("prec_cyc", 4, 0, 0);

    // Out-of-range select
    run(3, 4'b1111);
    rd_expect("sel7", 7, 0, 0);
    chk("sel7_valid", rv[0], 1);

    // en=0 drops events
    idle(); event_in = 4'hF;
    for (int i = 0; i < 8; i++) cyc();
    rd_expect("en0_ch0", 0, 3, 3);

    // Asynchronous reset between edges
    run(5, 4'b0110);
    #2; rst_n = 0; mreset();
    #1;
    check_all();
    chk("areset_rd", rd[1], 0);
    #1; rst_n = 1;

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      en       = ($urandom_range(0, 7) != 0);
      event_in = NC'($urandom);
      halt     = ($urandom_range(0, 149) == 0);
      clr      = ($urandom_range(0, 399) == 0);
      rd_req   = ($urandom_range(0, 3) != 0);
      rd_sel   = 3'($urandom_range(0, 7));
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
